sprite_animator: RTL and testbench
==================================

# sprite_animator

Parametrised sprite fetch engine for the VGA path: maps the current beam position (DrawX, DrawY) onto a multi-frame sprite stored in an external synchronous ROM, with per-frame position, integer power-of-two scaling, horizontal mirroring, animation-frame sequencing and optional transparency. Sits between the VGA controller and the palette/background mux. Outputs a palette index plus a hit flag; the parent selects sprite or background.

## Interface

Parameters:
- SPR_W, 54, sprite width in pixels
- SPR_H, 77, sprite height in pixels
- FRAMES, 4, animation frames stored consecutively in ROM
- ADDR_W, 15, ROM address width; must hold FRAMES*SPR_W*SPR_H-1
- IDX_W, 4, palette index width
- FRAME_HOLD, 6, video frames each animation frame is shown (≥1)
- V_ACTIVE, 480, first non-visible line; frame-boundary detect row
- TRANSPARENT_IDX, 0, index treated as see-through (see Configuration)

Ports:
- vga_clk  in  1  pixel clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  beam column
- DrawY  in  10  beam row
- blank  in  1  1 = visible display region
- pos_x  in  10  sprite top-left column (unsigned)
- pos_y  in  10  sprite top-left row (unsigned)
- scale  in  2  magnification = 1<<scale (1,2,4,8)
- flip_h  in  1  mirror sprite horizontally
- anim_en  in  1  enable frame advance
- anim_restart  in  1  force frame 0, hold count 0
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- sprite_hit  out  1  current output pixel is sprite-owned
- sprite_index  out  IDX_W  palette index for sprite pixel
- cur_frame  out  $clog2(FRAMES)  current animation frame

## Operation

- Frame boundary (fb): cycle where DrawX==0 and DrawY==V_ACTIVE. Single-cycle event per video frame.
- Shadow registers sh_x, sh_y, sh_scale, sh_flip load pos_x/pos_y/scale/flip_h on fb only; mid-frame input changes never tear the image.
- Animation: hold counter (0..FRAME_HOLD-1) increments on fb when anim_en=1. On fb with hold==FRAME_HOLD-1: hold→0, cur_frame→(cur_frame+1) mod FRAMES (wraps FRAMES-1→0). anim_en=0 freezes both.
- anim_restart, any cycle: cur_frame→0, hold→0; wins over a coincident fb advance. Shadow load on the same fb still occurs.
- Stage 0 (combinational → registered): dx = {1'b0,DrawX} - {1'b0,sh_x}, dy likewise, 11-bit two's complement. in_box = dx≥0 ∧ dx<(SPR_W<<sh_scale) ∧ dy≥0 ∧ dy<(SPR_H<<sh_scale). col = dx>>sh_scale; col' = sh_flip ? SPR_W-1-col : col; row = dy>>sh_scale. rom_address ← cur_frame*SPR_W*SPR_H + row*SPR_W + col' when in_box, else 0. in_box and blank pipelined alongside.
- Stage 1: ROM read (external).
- Stage 2: sprite_hit ← in_box_d2 ∧ blank_d2 ∧ opaque; sprite_index ← rom_q if hit else 0.
- Sprites partially off-screen (pos_x+width>639, etc.) clip naturally; no wrap to column 0.

## Timing

- Reset values: rom_address=0, sprite_hit=0, sprite_index=0, cur_frame=0, hold=0, sh_x=sh_y=0, sh_scale=0, sh_flip=0, pipeline flags 0.
- Latency: DrawX/DrawY/blank sampled at cycle N → sprite_hit/sprite_index valid at posedge ending cycle N+2 (3 registers incl. ROM). Parent delays its background path 3 cycles.
- Shadow/animation updates from fb at cycle N take effect for pixels sampled at N+1 onward.
- reset_n assertion mid-line: all outputs to reset values immediately (async); first output valid 3 cycles after release.

## Configuration

- SPRITE_TRANSPARENCY_EN defined: opaque = (rom_q != TRANSPARENT_IDX); transparent texels give sprite_hit=0, sprite_index=0.
- Undefined: opaque = 1; every in-box visible pixel hits, including TRANSPARENT_IDX.

## Test plan

- Reset: hold reset_n=0, sweep DrawX → rom_address, sprite_hit, sprite_index, cur_frame all 0.
- Placement: pos=(100,50), scale=0, flip=0, frame 0, after fb; beam (100,50) → rom_address 0, hit 3 cycles later; (153,50) → 53; (154,50) → hit 0; (100,126) row 76 → address 4104.
- Scale/flip: scale=1, flip_h=1; beam (pos_x+3, pos_y) → col 1 mirrored → rom_address 52; box width 108.
- Animation: anim_en=1, FRAME_HOLD=6; cur_frame 0→1 on 6th fb, 3→0 wrap after 24 fbs; anim_restart coincident with advancing fb → cur_frame 0; frame 2 origin address 2*4158=8316.
- Shadow latch: change pos_x mid-frame → address mapping unchanged until next fb.
- Transparency: rom_q=TRANSPARENT_IDX in-box → hit 0 with SPRITE_TRANSPARENCY_EN, hit 1 index 0 without; blank=0 → hit 0 in both builds.

Source files
------------

// File: rtl/sprite_animator.sv
// Sprite fetch engine: beam position -> ROM address, frame sequencing, hit flag.
// Build option: SPRITE_TRANSPARENCY_EN makes TRANSPARENT_IDX texels see-through.
module sprite_animator #(
    parameter int SPR_W           = 54,
    parameter int SPR_H           = 77,
    parameter int FRAMES          = 4,
    parameter int ADDR_W          = 15,
    parameter int IDX_W           = 4,
    parameter int FRAME_HOLD      = 6,
    parameter int V_ACTIVE        = 480,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      blank,
    input  logic [9:0]                pos_x,
    input  logic [9:0]                pos_y,
    input  logic [1:0]                scale,
    input  logic                      flip_h,
    input  logic                      anim_en,
    input  logic                      anim_restart,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [IDX_W-1:0]          rom_q,
    output logic                      sprite_hit,
    output logic [IDX_W-1:0]          sprite_index,
    output logic [$clog2(FRAMES)-1:0] cur_frame
);

    localparam int FW = $clog2(FRAMES);
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [IDX_W-1:0] TIDX = IDX_W'(TRANSPARENT_IDX);

`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    logic [9:0]  sh_x;
    logic [9:0]  sh_y;
    logic [1:0]  sh_scale;
    logic        sh_flip;
    logic [HW-1:0] hold;

    logic        fb;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] box_w;
    logic [10:0] box_h;
    logic        in_box;
    logic [9:0]  col;
    logic [9:0]  col_m;
    logic [9:0]  row;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] addr_n;

    logic        in_box_d1;
    logic        in_box_d2;
    logic        blank_d1;
    logic        blank_d2;
    logic        opaque;
    logic        hit_n;

    assign fb = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, sh_x};
        dy     = {1'b0, DrawY} - {1'b0, sh_y};
        box_w  = 11'(SPR_W) << sh_scale;
        box_h  = 11'(SPR_H) << sh_scale;
        in_box = !dx[10] && (dx < box_w)
              && !dy[10] && (dy < box_h);
        col    = dx[9:0] >> sh_scale;
        row    = dy[9:0] >> sh_scale;
        col_m  = sh_flip ? 10'(SPR_W - 1) - col : col;
        frame_base = ADDR_W'(cur_frame)
                   * ADDR_W'(SPR_W * SPR_H);
        addr_n = frame_base
               + ADDR_W'(row) * ADDR_W'(SPR_W)
               + ADDR_W'(col_m);
    end

    // Texels compare against the key only when the option is built in.
    assign opaque = !KEY_EN || (rom_q != TIDX);
    assign hit_n  = in_box_d2 && blank_d2 && opaque;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_scale <= '0;
            sh_flip  <= 1'b0;
        end else if (fb) begin
            sh_x     <= pos_x;
            sh_y     <= pos_y;
            sh_scale <= scale;
            sh_flip  <= flip_h;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_frame <= '0;
            hold      <= '0;
        end else if (anim_restart) begin
            cur_frame <= '0;
            hold      <= '0;
        end else if (fb && anim_en) begin
            if (hold == HW'(FRAME_HOLD - 1)) begin
                hold <= '0;
                if (cur_frame == FW'(FRAMES - 1))
                    cur_frame <= '0;
                else
                    cur_frame <= cur_frame + 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address  <= '0;
            in_box_d1    <= 1'b0;
            in_box_d2    <= 1'b0;
            blank_d1     <= 1'b0;
            blank_d2     <= 1'b0;
            sprite_hit   <= 1'b0;
            sprite_index <= '0;
        end else begin
            rom_address  <= in_box ? addr_n : '0;
            in_box_d1    <= in_box;
            in_box_d2    <= in_box_d1;
            blank_d1     <= blank;
            blank_d2     <= blank_d1;
            sprite_hit   <= hit_n;
            sprite_index <= hit_n ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_sprite_animator.sv
// Randomised bench for sprite_animator against an arithmetic reference model.
// Directed cases cover placement, scale/flip, transparency, latching, animation.
module tb_sprite_animator;

    localparam int SPR_W  = 54;
    localparam int SPR_H  = 77;
    localparam int FRAMES = 4;
    localparam int ADDR_W = 15;
    localparam int IDX_W  = 4;
    localparam int HOLD   = 6;
    localparam int V_ACT  = 480;
    localparam int TIDX   = 0;
    localparam int FSZ    = SPR_W * SPR_H;

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic              blank = 1'b0;
    logic [9:0]        pos_x = '0;
    logic [9:0]        pos_y = '0;
    logic [1:0]        scale = '0;
    logic              flip_h = 1'b0;
    logic              anim_en = 1'b0;
    logic              anim_restart = 1'b0;
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic              sprite_hit;
    logic [IDX_W-1:0]  sprite_index;
    logic [1:0]        cur_frame;

    logic [IDX_W-1:0]  rom_mem [FRAMES*FSZ];

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural state
    int m_sx, m_sy, m_ss, m_sf;
    int m_frame, m_hold;
    int q1_hit, q1_idx, q2_hit, q2_idx;
    int e_addr, e_hit, e_idx;

    sprite_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H),
        .FRAMES(FRAMES), .ADDR_W(ADDR_W),
        .IDX_W(IDX_W), .FRAME_HOLD(HOLD),
        .V_ACTIVE(V_ACT), .TRANSPARENT_IDX(TIDX)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y),
        .scale(scale), .flip_h(flip_h),
        .anim_en(anim_en),
        .anim_restart(anim_restart),
        .rom_address(rom_address),
        .rom_q(rom_q),
        .sprite_hit(sprite_hit),
        .sprite_index(sprite_index),
        .cur_frame(cur_frame)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk)
        rom_q <= rom_mem[rom_address];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_sx = 0; m_sy = 0; m_ss = 0; m_sf = 0;
        m_frame = 0; m_hold = 0;
        q1_hit = 0; q1_idx = 0;
        q2_hit = 0; q2_idx = 0;
    endtask

    task automatic m_edge();
        int s, dx, dy, col, row, a, h, ix;
        bit inb, fbv;
        s   = 1 << m_ss;
        dx  = int'(DrawX) - m_sx;
        dy  = int'(DrawY) - m_sy;
        inb = dx >= 0 && dx < SPR_W * s
           && dy >= 0 && dy < SPR_H * s;
        col = dx / s;
        if (m_sf != 0) col = SPR_W - 1 - col;
        row = dy / s;
        a   = inb ? m_frame * FSZ + row * SPR_W + col : 0;
        h   = (inb && blank) ? 1 : 0;
`ifdef SPRITE_TRANSPARENCY_EN
        if (int'(rom_mem[a]) == TIDX) h = 0;
`endif
        ix  = h ? int'(rom_mem[a]) : 0;
        e_addr = a;
        e_hit  = q2_hit;
        e_idx  = q2_idx;
        q2_hit = q1_hit; q2_idx = q1_idx;
        q1_hit = h;      q1_idx = ix;
        fbv = DrawX == 0 && DrawY == V_ACT;
        if (fbv) begin
            m_sx = pos_x; m_sy = pos_y;
            m_ss = scale; m_sf = flip_h;
        end
        if (anim_restart) begin
            m_frame = 0; m_hold = 0;
        end else if (fbv && anim_en) begin
            m_hold++;
            if (m_hold == HOLD) begin
                m_hold  = 0;
                m_frame = (m_frame + 1) % FRAMES;
            end
        end
    endtask

    task automatic drive(input int x, input int y,
                         input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        m_edge();
        #1;
        check("addr", rom_address, e_addr);
        check("frame", cur_frame, m_frame);
        check("hit", sprite_hit, e_hit);
        check("index", sprite_index, e_idx);
    endtask

    task automatic tick();
        drive(0, V_ACT, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, rom_address, 0);
        check({tag, "_hit"}, sprite_hit, 0);
        check({tag, "_idx"}, sprite_index, 0);
        check({tag, "_frame"}, cur_frame, 0);
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1 check_zero("async_rst");
        m_reset();
        for (int i = 0; i < 3; i++) begin
            DrawX = 10'($urandom_range(0, 639));
            @(posedge vga_clk);
            #1 check_zero("rst_hold");
        end
        reset_n = 1'b1;
    endtask

    task automatic place(input int x, input int y,
                         input int s, input bit f);
        pos_x = 10'(x); pos_y = 10'(y);
        scale = 2'(s);  flip_h = f;
        tick();
    endtask

    initial begin
        int rx, ry;
        for (int i = 0; i < FRAMES * FSZ; i++)
            rom_mem[i] = IDX_W'($urandom);
        rom_mem[0]    = 4'hA;
        rom_mem[1]    = IDX_W'(TIDX);
        rom_mem[52]   = 4'h5;
        rom_mem[53]   = 4'h7;
        rom_mem[4104] = 4'h9;
        m_reset();

        // reset held: sweep the beam
        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(i * 37);
            blank = 1'b1;
            @(posedge vga_clk);
            #1 check_zero("reset");
        end
        reset_n = 1'b1;

        // placement
        anim_restart = 1'b1;
        place(100, 50, 0, 1'b0);
        anim_restart = 1'b0;
        drive(100, 50, 1'b1);
        check("place_org", rom_address, 0);
        drive(153, 50, 1'b1);
        check("place_right", rom_address, 53);
        drive(154, 50, 1'b1);
        check("place_hit", sprite_hit, 1);
        check("place_hidx", sprite_index, 4'hA);
        drive(100, 126, 1'b1);
        check("place_row76", rom_address, 4104);
        drive(0, 0, 1'b0);
        check("place_clip", sprite_hit, 0);
        drive(0, 0, 1'b0);

        // scale x2 with mirror
        place(100, 50, 1, 1'b1);
        drive(103, 50, 1'b1);
        check("flip_addr", rom_address, 52);
        drive(207, 50, 1'b1);
        drive(208, 50, 1'b1);
        check("flip_hit", sprite_hit, 1);
        drive(0, 0, 1'b0);
        check("boxw_in", sprite_hit, 1);
        drive(0, 0, 1'b0);
        check("boxw_out", sprite_hit, 0);

        // transparency key and blanking
        place(100, 50, 0, 1'b0);
        drive(101, 50, 1'b1);
        drive(100, 50, 1'b0);
        drive(0, 0, 1'b0);
`ifdef SPRITE_TRANSPARENCY_EN
        check("key_hit", sprite_hit, 0);
`else
        check("key_hit", sprite_hit, 1);
`endif
        check("key_idx", sprite_index, 0);
        drive(0, 0, 1'b0);
        check("blank_hit", sprite_hit, 0);

        // shadow registers ignore mid-frame moves
        pos_x = 10'd300;
        drive(101, 50, 1'b1);
        check("shadow_hold", rom_address, 1);
        tick();
        drive(301, 50, 1'b1);
        check("shadow_load", rom_address, 1);
        pos_x = 10'd100;

        // animation sequencing
        anim_restart = 1'b1;
        drive(0, 0, 1'b0);
        anim_restart = 1'b0;
        anim_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("anim_hold5", cur_frame, 0);
        end
        check("anim_adv", cur_frame, 1);
        for (int i = 0; i < 12; i++) tick();
        check("anim_f3", cur_frame, 3);
        for (int i = 0; i < 6; i++) tick();
        check("anim_wrap", cur_frame, 0);
        for (int i = 0; i < 12; i++) tick();
        check("anim_f2", cur_frame, 2);
        drive(100, 50, 1'b1);
        check("f2_origin", rom_address, 8316);
        for (int i = 0; i < 5; i++) tick();
        anim_restart = 1'b1;
        tick();
        anim_restart = 1'b0;
        check("restart_win", cur_frame, 0);
        anim_en = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("anim_freeze", cur_frame, 0);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) reset_pulse();
            if ($urandom_range(0, 49) == 0) begin
                pos_x = 10'($urandom_range(0, 700));
                pos_y = 10'($urandom_range(0, 500));
                scale = 2'($urandom);
                flip_h = 1'($urandom);
            end
            anim_en = ($urandom_range(0, 3) != 0);
            anim_restart = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) begin
                tick();
            end else begin
                rx = m_sx - 10
                   + $urandom_range(0, SPR_W * 8 + 20);
                ry = m_sy - 10
                   + $urandom_range(0, SPR_H * 8 + 20);
                if (rx < 0) rx = 0;
                if (rx > 1023) rx = 1023;
                if (ry < 0) ry = 0;
                if (ry > 1023) ry = 1023;
                drive(rx, ry, $urandom_range(0, 3) != 0);
            end
        end
        anim_restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
